// File: rtl/mem_arbiter.sv
// Arbitrates fetch and data-stage requests onto one single-port memory.
// Data wins ties, and a wait-count timeout ends a transaction that never gets mem_ack.
module mem_arbiter #(
   parameter int unsigned AW      = 32,
   parameter int unsigned DW      = 32,
   parameter int unsigned TIMEOUT = 16
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          if_req,
   input  logic [AW-1:0] if_addr,
   output logic [DW-1:0] if_rdata,
   output logic          if_ready,
   output logic          if_stall,
   input  logic          dm_r,
   input  logic          dm_w,
   input  logic [AW-1:0] dm_addr,
   input  logic [DW-1:0] dm_wdata,
   output logic [DW-1:0] dm_rdata,
   output logic          dm_ready,
   output logic          dm_stall,
   output logic          mem_req,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   input  logic          mem_ack,
   output logic          err
);

   typedef enum logic [2:0] {StIdle, StBusyD, StBusyI, StDoneD, StDoneI} state_e;

   localparam logic [7:0] LastCnt = 8'(TIMEOUT - 1);

   state_e     state_q;
   logic [7:0] wait_cnt_q;
   logic       dm_any;
   logic       timeout;

   assign dm_any   = dm_r | dm_w;
   assign timeout  = (wait_cnt_q == LastCnt);
   assign if_stall = if_req & ~if_ready;
   assign dm_stall = dm_any & ~dm_ready;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= StIdle;
         wait_cnt_q <= 8'd0;
         mem_req    <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         if_rdata   <= '0;
         dm_rdata   <= '0;
         if_ready   <= 1'b0;
         dm_ready   <= 1'b0;
         err        <= 1'b0;
      end else begin
         if_ready <= 1'b0;
         dm_ready <= 1'b0;
         err      <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (dm_any) begin
                  state_q    <= StBusyD;
                  wait_cnt_q <= 8'd0;
                  mem_req    <= 1'b1;
                  mem_we     <= dm_w;
                  mem_addr   <= dm_addr;
                  mem_wdata  <= dm_wdata;
               end else if (if_req) begin
                  state_q    <= StBusyI;
                  wait_cnt_q <= 8'd0;
                  mem_req    <= 1'b1;
                  mem_we     <= 1'b0;
                  mem_addr   <= if_addr;
                  mem_wdata  <= '0;
               end
            end
            StBusyD: begin
               if (mem_ack) begin
                  state_q  <= StDoneD;
                  mem_req  <= 1'b0;
                  dm_ready <= 1'b1;
                  if (!mem_we) dm_rdata <= mem_rdata;
               end else if (timeout) begin
                  state_q  <= StDoneD;
                  mem_req  <= 1'b0;
                  dm_ready <= 1'b1;
                  err      <= 1'b1;
                  dm_rdata <= '0;
               end else begin
                  wait_cnt_q <= wait_cnt_q + 8'd1;
               end
            end
            StBusyI: begin
               if (mem_ack) begin
                  state_q  <= StDoneI;
                  mem_req  <= 1'b0;
                  if_ready <= 1'b1;
                  if_rdata <= mem_rdata;
               end else if (timeout) begin
                  state_q  <= StDoneI;
                  mem_req  <= 1'b0;
                  if_ready <= 1'b1;
                  err      <= 1'b1;
                  if_rdata <= '0;
               end else begin
                  wait_cnt_q <= wait_cnt_q + 8'd1;
               end
            end
            StDoneD, StDoneI: state_q <= StIdle;
            default:          state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter AW, default 32, address width.
REQ-002 Parameter DW, default 32, data width.
REQ-003 Parameter TIMEOUT, default 16, maximum BUSY cycles to wait for mem_ack; legal range 2..255.
REQ-004 Port: clk  in  1  single clock; all state updates on its rising edge.
REQ-005 Port: reset  in  1  asynchronous active-low reset.
REQ-006 Ports: if_req in 1, if_addr in AW  instruction-fetch request and address.
REQ-007 Ports: if_rdata out DW, if_ready out 1, if_stall out 1  fetch result, completion pulse, and stall indication.
REQ-008 Ports: dm_r in 1, dm_w in 1, dm_addr in AW, dm_wdata in DW  data-stage read/write request.
REQ-009 Ports: dm_rdata out DW, dm_ready out 1, dm_stall out 1  data result, completion pulse, and stall indication.
REQ-010 Ports: mem_req out 1, mem_we out 1, mem_addr out AW, mem_wdata out DW  shared single-port memory request.
REQ-011 Ports: mem_rdata in DW, mem_ack in 1  memory read data and completion.
REQ-012 Port: err out 1  one-cycle timeout pulse.

Function
REQ-013 FSM states SHALL be IDLE, BUSY_D, BUSY_I, DONE_D, DONE_I.
REQ-014 Requests SHALL be sampled only in IDLE; in all other states requests are ignored.
REQ-015 In IDLE, a data request (dm_r|dm_w) SHALL win over if_req → BUSY_D; if_req alone → BUSY_I; no request → stay in IDLE.
REQ-016 On an IDLE→BUSY_x edge, mem_addr, mem_wdata and mem_we SHALL be registered from the winner and held constant until leaving BUSY_x.
- Fetch: mem_we=0, mem_wdata=0.
REQ-017 mem_req SHALL be 1 exactly while in BUSY_D or BUSY_I.
REQ-018 dm_r and dm_w both high SHALL be treated as a write (mem_we=1).
REQ-019 BUSY_x with mem_ack=1 on an edge → DONE_x.
- Read: mem_rdata SHALL be captured into if_rdata or dm_rdata respectively.
- Write: dm_rdata SHALL be unchanged.
REQ-020 In BUSY_x, an 8-bit wait counter SHALL clear on entry and increment on each edge without mem_ack.
- On the edge where the count equals TIMEOUT-1 with no ack: → DONE_x, the read-data register SHALL load 0, and err SHALL be 1 during the DONE_x cycle.
REQ-021 if_ready SHALL be 1 only in DONE_I; dm_ready SHALL be 1 only in DONE_D; each lasts exactly one cycle. DONE_x → IDLE unconditionally.
REQ-022 if_stall = if_req & ~if_ready; dm_stall = (dm_r|dm_w) & ~dm_ready (combinational).
REQ-023 A requester holding its request past its ready cycle SHALL be served again as a new transaction.
REQ-024 mem_ack outside BUSY states (late or spurious) SHALL be ignored with no state or output change.
REQ-025 Minimum latency: request sampled at edge N, ack high before edge N+1 → ready high in cycle N+1..N+2; next grant sampled at edge N+3.
REQ-026 The read-data outputs SHALL hold their last value until the next completion on that port.

Reset
REQ-027 reset=0 SHALL immediately force: state IDLE, counter 0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, if_rdata=0, dm_rdata=0, if_ready=0, dm_ready=0, err=0.
REQ-028 Reset asserted during BUSY_x SHALL abort the transaction with no ready pulse; after reset release the first edge samples requests in IDLE.

Verification
REQ-029 Fetch read: if_req=1, if_addr=0x00400000, ack after 3 cycles with mem_rdata=0x2108000A → if_rdata=0x2108000A, one if_ready pulse, mem_we=0 throughout.
REQ-030 Contention: if_req and dm_r raised in the same cycle, dm_addr=0x10010004 → data served first (mem_addr=0x10010004), fetch granted at the next IDLE, if_stall high until its ready.
REQ-031 Write: dm_w=1, dm_addr=0x10010000, dm_wdata=0xCAFEF00D → mem_we=1 with that address/data held until ack, dm_rdata unchanged, dm_ready pulse.
REQ-032 Timeout: dm_r with mem_ack stuck 0, TIMEOUT=16 → mem_req high exactly 16 cycles, then dm_rdata=0, err and dm_ready high for one cycle; a later ack is ignored.
REQ-033 Reset mid-BUSY_I: assert reset 2 cycles after grant → mem_req falls asynchronously, no if_ready; after release with if_req=1, a fresh fetch completes normally.
REQ-034 dm_r=dm_w=1 → treated as write; held if_req after if_ready → second fetch issued.
